// File: rtl/shifter_arbiter.sv
// shifter_arbiter: round-robin sharing of one iterative Shifter between two requesters.
// Optional watchdog on the shifter handshake: define SHIFTER_ARBITER_TIMEOUT_EN.
module shifter_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 64
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic [1:0]   i_req_valid,
    output logic [1:0]   o_req_ready,
    input  logic         i_req0_direction,
    input  logic         i_req1_direction,
    input  logic         i_req0_rotate,
    input  logic         i_req1_rotate,
    input  logic [N-1:0] i_req0_iterations,
    input  logic [N-1:0] i_req1_iterations,
    input  logic [N-1:0] i_req0_value,
    input  logic [N-1:0] i_req1_value,
    output logic [1:0]   o_resp_valid,
    input  logic [1:0]   i_resp_ready,
    output logic [N-1:0] o_resp_value,
    output logic         o_resp_error,
    output logic         o_shift_start,
    input  logic         i_shift_finished,
    output logic         o_shift_direction,
    output logic         o_shift_rotate,
    output logic [N-1:0] o_shift_iterations,
    output logic [N-1:0] o_shift_value,
    input  logic [N-1:0] i_shift_value
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] WAIT    = 2'd2;
    localparam logic [1:0] RESPOND = 2'd3;

    logic [1:0]   state;
    logic         ptr;
    logic         winner;
    logic         sel;
    logic         sel_dir;
    logic         sel_rot;
    logic [N-1:0] sel_iter;
    logic [N-1:0] sel_val;
    logic         timeout;

    // The pointer port wins whenever it is requesting; otherwise the other port.
    always_comb begin
        sel         = i_req_valid[ptr] ? ptr : ~ptr;
        sel_dir     = sel ? i_req1_direction  : i_req0_direction;
        sel_rot     = sel ? i_req1_rotate     : i_req0_rotate;
        sel_iter    = sel ? i_req1_iterations : i_req0_iterations;
        sel_val     = sel ? i_req1_value      : i_req0_value;
        o_req_ready = (state == IDLE && |i_req_valid) ? {sel, ~sel} : 2'b00;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state              <= IDLE;
            ptr                <= 1'b0;
            winner             <= 1'b0;
            o_resp_valid       <= 2'b00;
            o_resp_value       <= '0;
            o_shift_start      <= 1'b0;
            o_shift_direction  <= 1'b0;
            o_shift_rotate     <= 1'b0;
            o_shift_iterations <= '0;
            o_shift_value      <= '0;
        end else begin
            o_shift_start <= 1'b0;
            case (state)
                IDLE: if (|i_req_valid) begin
                    winner             <= sel;
                    o_shift_direction  <= sel_dir;
                    o_shift_rotate     <= sel_rot;
                    o_shift_iterations <= sel_iter;
                    o_shift_value      <= sel_val;
                    if (sel_iter == '0) begin
                        o_resp_value <= sel_val;
                        o_resp_valid <= {sel, ~sel};
                        state        <= RESPOND;
                    end else begin
                        o_shift_start <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: if (i_shift_finished || timeout) begin
                    o_resp_value <= i_shift_finished ? i_shift_value : '0;
                    o_resp_valid <= {winner, ~winner};
                    state        <= RESPOND;
                end
                RESPOND: if (i_resp_ready[winner]) begin
                    ptr          <= ~winner;
                    o_resp_valid <= 2'b00;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SHIFTER_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;

    assign timeout = (state == WAIT) && !i_shift_finished && (cnt == CW'(TIMEOUT - 1));

    // Counter is held at zero outside WAIT, so it restarts on every entry.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            cnt          <= '0;
            o_resp_error <= 1'b0;
        end else begin
            cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
            if (state == IDLE || (state == WAIT && i_shift_finished))
                o_resp_error <= 1'b0;
            else if (timeout)
                o_resp_error <= 1'b1;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;
    assign timeout      = 1'b0;
    assign o_resp_error = 1'b0;
`endif
endmodule
